// File: rtl/alu_seq_pkg.sv
// Shared defaults, FSM encoding and command record layout
// for the ALU command sequencer and its command FIFO.
package alu_seq_pkg;

  localparam int W_DEF     = 8;
  localparam int SEL_W_DEF = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef struct packed {
    logic [W_DEF-1:0]     a;
    logic [W_DEF-1:0]     b;
    logic [SEL_W_DEF-1:0] sel;
  } cmd_t;

  function automatic int cmd_width(
    input int w,
    input int sel_w
  );
    return 2 * w + sel_w;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO for buffered ALU commands.
// Ports: push/wdata write, pop/rdata read, full/empty/count status.
module alu_cmd_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             do_push;
  logic             do_pop;

  // Extra top bit distinguishes full from empty
  // when the index bits match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count = wptr_q - rptr_q;
  assign rdata = mem_q[rptr_q[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wptr_d = wptr_q + PW'(do_push);
    rptr_d = rptr_q + PW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, drives them to the ALU, captures and returns Y.
// Ports: cmd_* in-stream, alu_* to/from ALU, res_* out-stream, busy, op_count.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int DEPTH    = 4,
  parameter int WAIT_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic [SEL_W-1:0] cmd_sel,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [W-1:0]     alu_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_y,
  output logic [SEL_W-1:0] res_sel,
  output logic             busy,
  output logic [7:0]       op_count
);

  localparam int CMD_W = cmd_width(W, SEL_W);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     alu_a_q, alu_a_d;
  logic [W-1:0]     alu_b_q, alu_b_d;
  logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic [W-1:0]     res_y_q, res_y_d;
  logic [SEL_W-1:0] res_sel_q, res_sel_d;
  logic [7:0]       op_count_q, op_count_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic [CMD_W-1:0] fifo_wdata;
  logic [CMD_W-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_count;

  // Held low during reset so commands offered then are dropped.
  assign cmd_ready  = !fifo_full && !rst;
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_wdata = {cmd_a, cmd_b, cmd_sel};

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    res_y_d    = res_y_q;
    res_sel_d  = res_sel_q;
    op_count_d = op_count_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          alu_a_d   = fifo_rdata[CMD_W-1 -: W];
          alu_b_d   = fifo_rdata[SEL_W +: W];
          alu_sel_d = fifo_rdata[SEL_W-1:0];
          cnt_d     = '0;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          res_y_d   = alu_y;
          res_sel_d = alu_sel_q;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          op_count_d = op_count_q + 8'd1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      res_y_q    <= '0;
      res_sel_q  <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      res_y_q    <= res_y_d;
      res_sel_q  <= res_sel_d;
      op_count_q <= op_count_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_valid = (state_q == ST_RESP);
  assign res_y     = res_y_q;
  assign res_sel   = res_sel_q;
  assign op_count  = op_count_q;
  assign busy      = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with an adder ALU stub
// and a result scoreboard.
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [2:0] cmd_sel;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_y;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_y;
  logic [2:0] res_sel;
  logic       busy;
  logic [7:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] sb [$];
  logic [7:0]  exp_ops;
  logic        hold_v;
  logic [7:0]  hold_y;
  logic [2:0]  hold_sel;

  assign alu_y = alu_a + alu_b;

  alu_cmd_sequencer #(
    .W        (8),
    .SEL_W    (3),
    .DEPTH    (4),
    .WAIT_CYC (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sel   (cmd_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_y     (alu_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_y     (res_y),
    .res_sel   (res_sel),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: records accepted commands, checks results in order,
  // op_count progression and result stability under backpressure.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_ops = 8'd0;
      hold_v  = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", {31'b0, res_valid}, 32'd1);
        check("hold_y", {24'b0, res_y}, {24'b0, hold_y});
        check("hold_sel", {29'b0, res_sel}, {29'b0, hold_sel});
      end
      if (res_valid && res_ready) begin
        check("mon_op_count", {24'b0, op_count}, {24'b0, exp_ops});
        check("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          logic [10:0] e;
          e = sb.pop_front();
          check("res_y", {24'b0, res_y}, {24'b0, e[7:0]});
          check("res_sel", {29'b0, res_sel}, {29'b0, e[10:8]});
        end
        exp_ops = exp_ops + 8'd1;
      end
      hold_v   = res_valid && !res_ready;
      hold_y   = res_y;
      hold_sel = res_sel;
      if (cmd_valid && cmd_ready) begin
        logic [7:0] s;
        s = cmd_a + cmd_b;
        sb.push_back({cmd_sel, s});
      end
    end
  end

  task automatic send(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] s,
    output int         waited
  );
    logic ok;
    cmd_a     = a;
    cmd_b     = b;
    cmd_sel   = s;
    cmd_valid = 1'b1;
    ok        = 1'b0;
    waited    = 0;
    while (!ok && waited < 100) begin
      @(negedge clk);
      ok = cmd_ready;
      waited++;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("send_accepted", {31'b0, ok}, 32'd1);
  endtask

  task automatic drain(input int limit);
    logic done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !busy;
    end
    check("drain_done", {31'b0, done}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    logic ok;

    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_a     = 8'hAA;
    cmd_b     = 8'h55;
    cmd_sel   = 3'd7;
    res_ready = 1'b0;

    // reset with a command offered
    repeat (2) begin
      @(negedge clk);
      check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_alu_a", {24'b0, alu_a}, 32'd0);
    check("rst_alu_b", {24'b0, alu_b}, 32'd0);
    check("rst_alu_sel", {29'b0, alu_sel}, 32'd0);
    check("rst_res_y", {24'b0, res_y}, 32'd0);
    check("rst_res_sel", {29'b0, res_sel}, 32'd0);
    check("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("rst_op_count", {24'b0, op_count}, 32'd0);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);

    // single op latency
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    send(8'h12, 8'h34, 3'd3, w);
    @(negedge clk);
    check("lat_e0_valid", {31'b0, res_valid}, 32'd0);
    @(negedge clk);
    check("lat_e1_valid", {31'b0, res_valid}, 32'd0);
    check("lat_e1_alu_a", {24'b0, alu_a}, 32'h12);
    @(negedge clk);
    check("lat_e2_valid", {31'b0, res_valid}, 32'd1);
    check("single_res_y", {24'b0, res_y}, 32'h46);
    check("single_res_sel", {29'b0, res_sel}, 32'd3);
    @(negedge clk);
    check("single_op_count", {24'b0, op_count}, 32'd1);
    check("single_valid_low", {31'b0, res_valid}, 32'd0);

    // fill and backpressure
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(8'(i * 16 + 1), 8'(i * 3), 3'(i), w);
      check("fill_no_wait", w, 32'd1);
    end
    cmd_a     = 8'h70;
    cmd_b     = 8'h07;
    cmd_sel   = 3'd6;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("full_res_valid", {31'b0, res_valid}, 32'd1);
      check("full_busy", {31'b0, busy}, 32'd1);
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    w  = 0;
    ok = 1'b0;
    while (!ok && w < 50) begin
      @(negedge clk);
      w++;
      ok = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("sixth_accept_wait", w, 32'd3);
    drain(100);
    check("fill_op_count", {24'b0, op_count}, 32'd7);

    // result hold: 0xFF + 0x01 wraps to 0x00
    res_ready = 1'b0;
    send(8'hFF, 8'h01, 3'd5, w);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = res_valid;
    end
    check("hold_seen_valid", {31'b0, ok}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold5_valid", {31'b0, res_valid}, 32'd1);
      check("hold5_y", {24'b0, res_y}, 32'h00);
      check("hold5_sel", {29'b0, res_sel}, 32'd5);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    drain(50);
    check("hold_op_count", {24'b0, op_count}, 32'd8);

    // reset while in SETTLE with two queued
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(8'(8'h20 + i), 8'h01, 3'(i + 1), w);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_valid", {31'b0, res_valid}, 32'd0);
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    check("pre_rst_alu_a", {24'b0, alu_a}, 32'h21);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", {31'b0, res_valid}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_op_count", {24'b0, op_count}, 32'd0);
    rst       = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_valid", {31'b0, res_valid}, 32'd0);
      check("post_rst_busy", {31'b0, busy}, 32'd0);
      check("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
    end
    @(posedge clk);
    #1;

    // pointer wrap and op_count wrap
    for (int i = 0; i < 260; i++) begin
      send(8'($urandom), 8'($urandom), 3'($urandom), w);
    end
    drain(200);
    check("wrap_op_count", {24'b0, op_count}, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the 8-bit ALU datapath.
- Accepts operation commands (A, B, sel) over a valid/ready stream and buffers them in a small FIFO.
- Drives each command onto the ALU's combinational inputs as registered values, waits a fixed settle time, captures Y, and returns it on a valid/ready result stream.
- Sits between the pin/command front end and the combinational ALU core.

Parameters:
- W, 8, operand and result width.
- SEL_W, 3, opcode selector width.
- DEPTH, 4, command FIFO entries (power of two, at least 2).
- WAIT_CYC, 1, ALU settle cycles before capture (at least 1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept.
- cmd_a  in  W  operand A.
- cmd_b  in  W  operand B.
- cmd_sel  in  SEL_W  ALU opcode.
- alu_a  out  W  registered operand A to ALU.
- alu_b  out  W  registered operand B to ALU.
- alu_sel  out  SEL_W  registered opcode to ALU.
- alu_y  in  W  ALU result (combinational from alu_a/alu_b/alu_sel).
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_y  out  W  captured result.
- res_sel  out  SEL_W  opcode echo of the captured result.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- op_count  out  8  completed result handshakes, wraps 255->0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO emptied, FSM forced to IDLE, settle counter cleared.
  - alu_a, alu_b, alu_sel, res_y, res_sel and op_count all 0; res_valid 0.
  - cmd_ready = !full && !rst, so it is 0 while rst is high and commands presented during reset are dropped.
  - Reset mid-operation discards buffered and in-flight commands. No partial result is emitted.
- Command push: on cmd_valid && cmd_ready at an edge, write {cmd_a, cmd_b, cmd_sel}. When full, cmd_ready=0 and pushes are ignored.
- FSM states IDLE, SETTLE, RESP:
  - IDLE: if the FIFO is non-empty, pop the head, load alu_a/alu_b/alu_sel, clear the counter, go to SETTLE. Otherwise stay.
  - SETTLE: increment the counter each cycle. At the edge where counter==WAIT_CYC-1, capture res_y<=alu_y and res_sel<=alu_sel, then go to RESP.
  - RESP: res_valid=1. On res_ready, increment op_count and go to IDLE. Otherwise hold.
- Stability rules:
  - alu_a, alu_b and alu_sel remain stable from load until the next pop. They are not cleared after RESP.
  - res_y and res_sel remain stable while res_valid && !res_ready.
- Latency:
  - With an empty FIFO and IDLE, a command accepted at edge e0 is popped at e1 and captured at e1+WAIT_CYC.
  - res_valid is therefore high after edge e0+WAIT_CYC+1.
  - Back-to-back throughput is one result per WAIT_CYC+2 cycles: one IDLE bubble after each handshake.
- Simultaneous push and pop in the same cycle (FIFO not full): both occur and the occupancy is unchanged.
- Push when the FIFO is empty while IDLE: there is no bypass. The pop happens on the following edge.
- Pointer wrap: read and write pointers are log2(DEPTH) bits plus one extra wrap bit. full and empty are derived from pointer comparison.
- busy = (occupancy != 0) || (state != IDLE).
- res_valid is driven purely from the state register; it has no combinational path from res_ready.
- No arithmetic is performed in this block. Widths pass through unchanged.

Decomposition:
- alu_seq_pkg holds W and SEL_W defaults, the FSM state encoding (IDLE=0, SETTLE=1, RESP=2) and the command record layout {a, b, sel} of width 2W+SEL_W.
- One sub-module: alu_cmd_fifo.
  - Synchronous FIFO, parameterised by width and DEPTH.
  - Ports: push, pop, wdata, rdata, full, empty, count; same clk/rst.
- The FSM, settle counter and result registers live in alu_cmd_sequencer.

Test Plan:
- Bench stub: alu_y = alu_a + alu_b (mod 256), WAIT_CYC=1.
- Reset: hold rst 2 cycles with cmd_valid=1 -> no push; after release all outputs 0, cmd_ready=1, busy=0.
- Single op: push a=0x12, b=0x34, sel=3 at edge e0, res_ready=1 -> res_valid high after e0+2, res_y=0x46, res_sel=3, op_count=1.
- Fill and backpressure: res_ready=0, push 6 commands back-to-back -> 4 in the FIFO plus 1 in flight, then cmd_ready=0. The 6th command is accepted only after the first pop; the FIFO never exceeds 4 entries.
- Result hold and ordering: hold res_ready=0 for 5 cycles on result 0xFF+0x01 -> res_y=0x00 stays stable. Release res_ready -> results emerge in push order; op_count counts each handshake.
- Reset mid-op: assert rst while in SETTLE with 2 entries queued -> next cycle res_valid=0, busy=0, FIFO empty, and no stale result after release.
- Wrap: run 260 ops with res_ready=1 -> op_count=4; FIFO pointers wrap correctly and there is no data corruption versus a reference queue.
